soc_system_niosii_cpu_debug_monmem: RTL and testbench

Sysclk-domain consumer of the debug slave's decoded JTAG commands (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a). It turns them into single-word Avalon-MM master accesses on the CPU debug memory port. It returns MonDReg, monitor_ready and monitor_error to the debug slave's TCK-side scan chain. It holds the monitor address register, with optional auto-increment for block transfers.

---
 rtl/soc_system_niosii_dbg_pkg.sv | 17 +
 rtl/soc_system_niosii_dbg_timeout.sv | 32 +++
 rtl/soc_system_niosii_cpu_debug_monmem.sv | 140 ++++++++++++++
 tb/tb_soc_system_niosii_cpu_debug_monmem.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_niosii_dbg_pkg.sv
// Shared types and jdo field positions for the Nios II debug memory monitor.
package soc_system_niosii_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } dbg_state_e;

    localparam int JDO_RD       = 34;
    localparam int JDO_INC      = 35;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_DATA_LSB = 3;
    localparam int TIMEOUT_W    = 8;

endpackage

// File: rtl/soc_system_niosii_dbg_timeout.sv
// Cycle budget for one bus-wait state: counts while en_i and flags the TIMEOUT-th cycle.
// term_o comes straight off the registered count; clr_i wins and holds the count at zero.
module soc_system_niosii_dbg_timeout
    import soc_system_niosii_dbg_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam logic [TIMEOUT_W-1:0] TERM_CNT = TIMEOUT_W'(TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] cnt_q;

    assign term_o = (cnt_q == TERM_CNT);

    // Saturates on the terminal value so a stuck caller never wraps back to a fresh budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !term_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/soc_system_niosii_cpu_debug_monmem.sv
// Turns decoded JTAG ocimem commands into single-word Avalon-MM reads/writes on the debug port.
// Zero-wait read: strobe to monitor_ready in 3 cycles, write in 2; strobes seen while busy are dropped and flagged.
module soc_system_niosii_cpu_debug_monmem
    import soc_system_niosii_dbg_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    dbg_state_e        state_q;
    logic [31:0]       mon_d_q;
    logic [ADDR_W-1:0] mon_a_q;
    logic [31:0]       wdata_q;
    logic              rd_q;
    logic              wr_q;
    logic              ready_q;
    logic              err_q;
    logic              inc_q;
    logic              busy_err_q;

    logic any_strobe;
    logic busy;
    logic progress;
    logic done;
    logic abort;
    logic tmo_term;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign busy       = (state_q != IDLE);
    assign progress   = (state_q == RD_REQ) && !avm_waitrequest;
    assign done       = (progress && avm_readdatavalid)
                      || ((state_q == RD_WAIT) && avm_readdatavalid)
                      || ((state_q == WR_REQ) && !avm_waitrequest);
    // A handshake that lands on the terminal cycle still counts as progress, not a timeout.
    assign abort      = busy && tmo_term && !done && !progress;

    soc_system_niosii_dbg_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (reset_n),
        .clr_i  (!busy || progress),
        .en_i   (busy),
        .term_o (tmo_term)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mon_d_q    <= '0;
            mon_a_q    <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            inc_q      <= 1'b0;
            busy_err_q <= 1'b0;
        end else if (busy) begin
            if (any_strobe) begin
                busy_err_q <= 1'b1;
            end
            if (done) begin
                state_q <= IDLE;
                rd_q    <= 1'b0;
                wr_q    <= 1'b0;
                ready_q <= 1'b1;
                err_q   <= busy_err_q | any_strobe;
                if (state_q != WR_REQ) begin
                    mon_d_q <= avm_readdata;
                end
                if (inc_q) begin
                    mon_a_q <= mon_a_q + 1'b1;
                end
            end else if (abort) begin
                state_q <= IDLE;
                rd_q    <= 1'b0;
                wr_q    <= 1'b0;
                ready_q <= 1'b1;
                err_q   <= 1'b1;
            end else if (progress) begin
                state_q <= RD_WAIT;
                rd_q    <= 1'b0;
            end
        end else if (take_action_ocimem_a) begin
            mon_a_q    <= jdo[JDO_ADDR_LSB +: ADDR_W];
            inc_q      <= jdo[JDO_INC];
            err_q      <= 1'b0;
            busy_err_q <= 1'b0;
            ready_q    <= !jdo[JDO_RD];
            rd_q       <= jdo[JDO_RD];
            state_q    <= jdo[JDO_RD] ? RD_REQ : IDLE;
        end else if (take_action_ocimem_b) begin
            mon_d_q    <= jdo[JDO_DATA_LSB +: 32];
            wdata_q    <= jdo[JDO_DATA_LSB +: 32];
            wr_q       <= 1'b1;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_err_q <= 1'b0;
            state_q    <= WR_REQ;
        end else if (take_no_action_ocimem_a && jdo[JDO_RD]) begin
            rd_q       <= 1'b1;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_err_q <= 1'b0;
            state_q    <= RD_REQ;
        end
    end

    assign avm_address   = mon_a_q;
    assign avm_read      = rd_q;
    assign avm_write     = wr_q;
    assign avm_writedata = wdata_q;
    assign MonDReg       = mon_d_q;
    assign MonAReg       = mon_a_q;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;

endmodule

// File: tb/tb_soc_system_niosii_cpu_debug_monmem.sv
// Directed bench for the debug memory monitor against a small Avalon slave model.
module tb_soc_system_niosii_cpu_debug_monmem;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [8:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] MonDReg;
    logic [8:0]  MonAReg;
    logic        monitor_ready;
    logic        monitor_error;

    soc_system_niosii_cpu_debug_monmem #(
        .ADDR_W  (9),
        .TIMEOUT (255)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_waitrequest         (avm_waitrequest),
        .avm_readdata            (avm_readdata),
        .avm_readdatavalid       (avm_readdatavalid),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    // Slave model knobs, written only by the stimulus process.
    int          stall_cfg = 0;
    bit          drop_rd = 1'b0;
    bit          inj_rdv = 1'b0;
    logic [31:0] inj_dat = '0;
    logic [31:0] ovr5 = 32'hDEAD_BEEF;

    // Slave model state, written only by the model process.
    logic [31:0] mem [512];
    bit          written [512];
    int          stall_cnt = 0;
    bit          pend_rdv = 1'b0;
    logic [31:0] pend_dat = '0;
    int          rd_cycles = 0;
    int          rd_acc = 0;
    logic [8:0]  rd_addr = '0;
    int          wr_cycles = 0;
    int          both_hi = 0;

    function automatic logic [31:0] mem_val(input logic [8:0] a);
        if (written[a]) return mem[a];
        if (a == 9'd5)  return ovr5;
        return 32'hA000_0000 | {23'd0, a};
    endfunction

    always @(negedge clk) begin
        avm_readdatavalid = pend_rdv | inj_rdv;
        avm_readdata      = pend_rdv ? pend_dat : inj_dat;
        pend_rdv          = 1'b0;
        if (avm_read && avm_write) both_hi++;
        if (avm_read || avm_write) begin
            avm_waitrequest = (stall_cnt < stall_cfg);
            if (avm_waitrequest) stall_cnt++;
        end else begin
            avm_waitrequest = 1'b0;
            stall_cnt       = 0;
        end
        if (avm_read) rd_cycles++;
        if (avm_read && !avm_waitrequest) begin
            rd_acc++;
            rd_addr = avm_address;
            if (!drop_rd) begin
                pend_rdv = 1'b1;
                pend_dat = mem_val(avm_address);
            end
        end
        if (avm_write) wr_cycles++;
        if (avm_write && !avm_waitrequest) begin
            mem[avm_address]     = avm_writedata;
            written[avm_address] = 1'b1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] ja(input logic inc, input logic rd, input logic [8:0] a);
        logic [37:0] j;
        j        = '0;
        j[35]    = inc;
        j[34]    = rd;
        j[25:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] jb(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic strobe(input logic a, input logic b, input logic na, input logic [37:0] d);
        @(negedge clk);
        jdo                     = d;
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = na;
        @(negedge clk);
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    // lat counts clock edges from the strobe edge up to the one that raises monitor_ready.
    task automatic wait_ready(input int budget, output int lat);
        lat = 1;
        while (!monitor_ready && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (!monitor_ready) chk("ready_wait", {31'd0, monitor_ready}, 32'd1);
        #1;
    endtask

    int lat;
    int base_rd;
    int base_wr;
    int base_cyc;

    initial begin
        #12;
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_monareg", {23'd0, MonAReg}, 32'd0);
        chk("rst_read", {31'd0, avm_read}, 32'd0);
        chk("rst_write", {31'd0, avm_write}, 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_ready", {31'd0, monitor_ready}, 32'd1);
        chk("rst_error", {31'd0, monitor_error}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Zero-wait read of address 5.
        base_rd = rd_acc; base_cyc = rd_cycles;
        strobe(1'b1, 1'b0, 1'b0, ja(1'b0, 1'b1, 9'd5));
        wait_ready(20, lat);
        chk("rd_latency", lat, 32'd3);
        chk("rd_data", MonDReg, 32'hDEAD_BEEF);
        chk("rd_error", {31'd0, monitor_error}, 32'd0);
        chk("rd_accepts", rd_acc - base_rd, 32'd1);
        chk("rd_cycles", rd_cycles - base_cyc, 32'd1);
        chk("rd_addr", {23'd0, rd_addr}, 32'd5);
        chk("rd_no_inc", {23'd0, MonAReg}, 32'd5);

        // Re-read at the held address; jdo address field must be ignored.
        ovr5 = 32'h5555_AAAA;
        strobe(1'b0, 1'b0, 1'b1, ja(1'b0, 1'b1, 9'd9));
        wait_ready(20, lat);
        chk("reread_latency", lat, 32'd3);
        chk("reread_data", MonDReg, 32'h5555_AAAA);
        chk("reread_addr", {23'd0, rd_addr}, 32'd5);

        // Address load without read, then stalled write with wrap-around increment.
        strobe(1'b1, 1'b0, 1'b0, ja(1'b1, 1'b0, 9'h1FF));
        wait_ready(20, lat);
        chk("aload_latency", lat, 32'd1);
        chk("aload_addr", {23'd0, MonAReg}, 32'h1FF);
        base_wr = wr_cycles;
        stall_cfg = 4;
        strobe(1'b0, 1'b1, 1'b0, jb(32'h1234_5678));
        wait_ready(40, lat);
        stall_cfg = 0;
        chk("wr_latency", lat, 32'd6);
        chk("wr_cycles", wr_cycles - base_wr, 32'd5);
        chk("wr_wrap", {23'd0, MonAReg}, 32'd0);
        chk("wr_mem", mem_val(9'h1FF), 32'h1234_5678);
        chk("wr_mondreg", MonDReg, 32'h1234_5678);
        chk("wr_error", {31'd0, monitor_error}, 32'd0);

        // Read whose data never returns: 1 RD_REQ cycle plus 255 RD_WAIT cycles.
        drop_rd = 1'b1;
        strobe(1'b1, 1'b0, 1'b0, ja(1'b1, 1'b1, 9'h0A));
        wait_ready(400, lat);
        drop_rd = 1'b0;
        chk("tmo_latency", lat, 32'd257);
        chk("tmo_error", {31'd0, monitor_error}, 32'd1);
        chk("tmo_mondreg", MonDReg, 32'h1234_5678);
        chk("tmo_no_inc", {23'd0, MonAReg}, 32'h0A);
        inj_dat = 32'hCAFE_F00D;
        inj_rdv = 1'b1;
        @(negedge clk); @(negedge clk);
        #1 inj_rdv = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("late_rdv_data", MonDReg, 32'h1234_5678);
        chk("late_rdv_ready", {31'd0, monitor_ready}, 32'd1);

        // Write strobe while a read is stalled: dropped, error raised at completion.
        base_wr = wr_cycles;
        stall_cfg = 10;
        strobe(1'b1, 1'b0, 1'b0, ja(1'b0, 1'b1, 9'd7));
        strobe(1'b0, 1'b1, 1'b0, jb(32'hBBBB_BBBB));
        wait_ready(100, lat);
        stall_cfg = 0;
        chk("busy_data", MonDReg, 32'hA000_0007);
        chk("busy_error", {31'd0, monitor_error}, 32'd1);
        chk("busy_no_write", wr_cycles - base_wr, 32'd0);
        strobe(1'b1, 1'b0, 1'b0, ja(1'b0, 1'b0, 9'd2));
        wait_ready(20, lat);
        chk("busy_err_clear", {31'd0, monitor_error}, 32'd0);
        chk("busy_next_addr", {23'd0, MonAReg}, 32'd2);

        // Coincident ocimem_a (read) and ocimem_b: only the read happens.
        base_rd = rd_acc; base_wr = wr_cycles;
        strobe(1'b1, 1'b1, 1'b0, ja(1'b0, 1'b1, 9'd3));
        wait_ready(20, lat);
        chk("prio_accepts", rd_acc - base_rd, 32'd1);
        chk("prio_addr", {23'd0, rd_addr}, 32'd3);
        chk("prio_data", MonDReg, 32'hA000_0003);
        chk("prio_no_write", wr_cycles - base_wr, 32'd0);
        chk("prio_error", {31'd0, monitor_error}, 32'd0);

        // Read with increment.
        strobe(1'b1, 1'b0, 1'b0, ja(1'b1, 1'b1, 9'd8));
        wait_ready(20, lat);
        chk("rdinc_data", MonDReg, 32'hA000_0008);
        chk("rdinc_addr", {23'd0, MonAReg}, 32'd9);

        // Asynchronous reset while a write is stalled.
        stall_cfg = 100;
        strobe(1'b0, 1'b1, 1'b0, jb(32'h7777_7777));
        @(negedge clk); #1;
        chk("arst_pre_write", {31'd0, avm_write}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_write", {31'd0, avm_write}, 32'd0);
        chk("arst_read", {31'd0, avm_read}, 32'd0);
        chk("arst_wdata", avm_writedata, 32'd0);
        chk("arst_mondreg", MonDReg, 32'd0);
        chk("arst_monareg", {23'd0, MonAReg}, 32'd0);
        chk("arst_ready", {31'd0, monitor_ready}, 32'd1);
        chk("arst_error", {31'd0, monitor_error}, 32'd0);
        stall_cfg = 0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        chk("arst_mem", mem_val(9'd9), 32'hA000_0009);
        strobe(1'b1, 1'b0, 1'b0, ja(1'b0, 1'b1, 9'd5));
        wait_ready(20, lat);
        chk("post_rst_latency", lat, 32'd3);
        chk("post_rst_data", MonDReg, 32'h5555_AAAA);

        chk("never_both", both_hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
